// File: rtl/gp9001_host_if.sv
// GP9001 host command processor: turns level-held CPU op strobes into VRAM pointer,
// register-file and VRAM port actions, answering each op with a held ACK.
module gp9001_host_if #(
  parameter int unsigned AW     = 14,
  parameter int unsigned NREG   = 16,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                 CLK96,
  input  logic                 RESET96,
  input  logic                 OP_SET_RAM_PTR,
  input  logic                 OP_SELECT_REG,
  input  logic                 OP_WRITE_REG,
  input  logic                 OP_WRITE_RAM,
  input  logic                 OP_READ_RAM_H,
  input  logic                 OP_READ_RAM_L,
  input  logic [15:0]          DIN,
  output logic [15:0]          DOUT,
  output logic                 ACK,
  input  logic                 LVBL,
  output logic [AW-1:0]        VRAM_ADDR,
  output logic [15:0]          VRAM_DIN,
  output logic                 VRAM_WE,
  input  logic [15:0]          VRAM_Q,
  output logic [16*NREG-1:0]   REGS,
  output logic [16*NREG-1:0]   REGS_FRAME
);

  localparam int unsigned IW = $clog2(NREG);
  localparam int unsigned CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RD_WAIT, S_DONE} state_e;
  typedef enum logic [2:0] {OP_NONE, OP_PTR, OP_SEL, OP_WREG, OP_WRAM, OP_RDH, OP_RDL} op_e;

  state_e               state_q, state_d;
  op_e                  op_q, op_req;
  logic [15:0]          din_q;
  logic [AW-1:0]        ptr_q;
  logic [IW-1:0]        idx_q;
  logic [CW-1:0]        cnt_q;
  logic [15:0]          dout_q;
  logic                 ack_q, ack_d;
  logic [AW-1:0]        vram_addr_q;
  logic [15:0]          vram_din_q;
  logic                 vram_we_q;
  logic                 lvbl_q;
  logic [NREG-1:0][15:0] regs_q;
  logic [NREG-1:0][15:0] frame_q;

  logic any_op, accept, exec, rd_last, capture, op_is_read;

  assign any_op = OP_SET_RAM_PTR | OP_SELECT_REG | OP_WRITE_REG |
                  OP_WRITE_RAM | OP_READ_RAM_H | OP_READ_RAM_L;

  always_comb begin
    op_req = OP_NONE;
    if      (OP_SET_RAM_PTR) op_req = OP_PTR;
    else if (OP_SELECT_REG)  op_req = OP_SEL;
    else if (OP_WRITE_REG)   op_req = OP_WREG;
    else if (OP_WRITE_RAM)   op_req = OP_WRAM;
    else if (OP_READ_RAM_H)  op_req = OP_RDH;
    else if (OP_READ_RAM_L)  op_req = OP_RDL;
  end

  assign op_is_read = (op_q == OP_RDH) || (op_q == OP_RDL);
  assign rd_last    = (cnt_q == CW'(RD_LAT - 1));

  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (any_op) state_d = S_EXEC;
      S_EXEC:    state_d = op_is_read ? S_RD_WAIT : S_DONE;
      S_RD_WAIT: if (rd_last) state_d = S_DONE;
      S_DONE:    if (!any_op) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    accept  = (state_q == S_IDLE) && any_op;
    exec    = (state_q == S_EXEC);
    capture = (state_q == S_RD_WAIT) && rd_last;
    ack_d   = (state_q == S_DONE) && any_op;
  end

  // VRAM port is registered at acceptance so address, data and WE are valid for the whole EXEC clock.
  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96) begin
      op_q        <= OP_NONE;
      din_q       <= '0;
      ptr_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      dout_q      <= '0;
      ack_q       <= 1'b0;
      vram_addr_q <= '0;
      vram_din_q  <= '0;
      vram_we_q   <= 1'b0;
      lvbl_q      <= 1'b0;
      regs_q      <= '0;
      frame_q     <= '0;
    end else begin
      ack_q     <= ack_d;
      vram_we_q <= accept && (op_req == OP_WRAM);
      if (accept) begin
        op_q  <= op_req;
        din_q <= DIN;
        if (op_req == OP_WRAM || op_req == OP_RDH || op_req == OP_RDL) vram_addr_q <= ptr_q;
        if (op_req == OP_WRAM) vram_din_q <= DIN;
      end
      if (exec) begin
        cnt_q <= '0;
        unique case (op_q)
          OP_PTR:  ptr_q <= din_q[AW-1:0];
          OP_SEL:  idx_q <= din_q[IW-1:0];
          OP_WREG: regs_q[idx_q] <= din_q;
          OP_WRAM: ptr_q <= ptr_q + 1'b1;
          default: ;
        endcase
      end else if (state_q == S_RD_WAIT) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (capture) begin
        dout_q <= VRAM_Q;
        if (op_q == OP_RDL) ptr_q <= ptr_q + 1'b1;
      end
      // Frame copy samples the pre-write register file, so a coincident WRITE_REG lands next frame.
      lvbl_q <= LVBL;
      if (lvbl_q && !LVBL) frame_q <= regs_q;
    end
  end

  assign DOUT       = dout_q;
  assign ACK        = ack_q;
  assign VRAM_ADDR  = vram_addr_q;
  assign VRAM_DIN   = vram_din_q;
  assign VRAM_WE    = vram_we_q;
  assign REGS       = regs_q;
  assign REGS_FRAME = frame_q;

endmodule

// File: tb/tb_gp9001_host_if.sv
// Bench for gp9001_host_if: directed vector table, hand-written handshake/frame/reset
// sequences, and randomized ops checked against an op-level reference model.
module tb_gp9001_host_if;
  localparam int unsigned AW = 14, NREG = 16, RD_LAT = 1;
  localparam int unsigned RW = 16 * NREG;
  localparam int unsigned IW = $clog2(NREG);
  localparam logic [5:0] M_SET = 6'b100000, M_SEL = 6'b010000, M_WREG = 6'b001000,
                         M_WRAM = 6'b000100, M_RH = 6'b000010, M_RL = 6'b000001;

  logic clk = 1'b0, rst = 1'b0;
  logic op_set = 0, op_sel = 0, op_wreg = 0, op_wram = 0, op_rh = 0, op_rl = 0;
  logic [15:0] din = '0, dout, vdin, vq;
  logic ack, vwe, lvbl = 1'b1;
  logic [AW-1:0] vaddr;
  logic [RW-1:0] regs, regs_frame;

  always #5 clk = ~clk;

  gp9001_host_if #(.AW(AW), .NREG(NREG), .RD_LAT(RD_LAT)) dut (
    .CLK96(clk), .RESET96(rst),
    .OP_SET_RAM_PTR(op_set), .OP_SELECT_REG(op_sel), .OP_WRITE_REG(op_wreg),
    .OP_WRITE_RAM(op_wram), .OP_READ_RAM_H(op_rh), .OP_READ_RAM_L(op_rl),
    .DIN(din), .DOUT(dout), .ACK(ack), .LVBL(lvbl),
    .VRAM_ADDR(vaddr), .VRAM_DIN(vdin), .VRAM_WE(vwe), .VRAM_Q(vq),
    .REGS(regs), .REGS_FRAME(regs_frame)
  );

  // Unwritten VRAM words read back as a fixed function of their address.
  function automatic logic [15:0] fill(input logic [AW-1:0] a);
    return 16'(a) ^ 16'h5A5A;
  endfunction

  logic [15:0] mem   [0:(1<<AW)-1];
  bit          wflag [0:(1<<AW)-1];
  logic [15:0] pipe  [RD_LAT];
  always @(posedge clk) begin
    if (vwe) begin
      mem[vaddr]   <= vdin;
      wflag[vaddr] <= 1'b1;
    end
    pipe[0] <= wflag[vaddr] ? mem[vaddr] : fill(vaddr);
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign vq = pipe[RD_LAT-1];

  // Reference model: state after each whole op.
  logic [AW-1:0] m_ptr, m_addr;
  logic [IW-1:0] m_idx;
  logic [15:0]   m_dout;
  logic [15:0]   m_regs  [NREG];
  logic [15:0]   m_frame [NREG];
  logic [15:0]   m_mem   [int];

  task automatic m_reset();
    m_ptr = '0; m_addr = '0; m_idx = '0; m_dout = '0;
    for (int i = 0; i < NREG; i++) begin m_regs[i] = '0; m_frame[i] = '0; end
  endtask

  function automatic logic [15:0] m_rd(input logic [AW-1:0] a);
    return m_mem.exists(int'(a)) ? m_mem[int'(a)] : fill(a);
  endfunction

  function automatic logic [RW-1:0] pack(input logic [15:0] r [NREG]);
    logic [RW-1:0] v;
    for (int i = 0; i < NREG; i++) v[16*i +: 16] = r[i];
    return v;
  endfunction

  task automatic m_apply(input logic [5:0] mask, input logic [15:0] d, output bit we, output int lat);
    int top = -1;
    for (int b = 0; b < 6; b++) if (mask[b]) top = b;
    we = 0; lat = 3;
    case (top)
      5: m_ptr = d[AW-1:0];
      4: m_idx = d[IW-1:0];
      3: m_regs[m_idx] = d;
      2: begin we = 1; m_addr = m_ptr; m_mem[int'(m_ptr)] = d; m_ptr = m_ptr + 1'b1; end
      1: begin m_addr = m_ptr; m_dout = m_rd(m_ptr); lat = 3 + RD_LAT; end
      0: begin m_addr = m_ptr; m_dout = m_rd(m_ptr); lat = 3 + RD_LAT; m_ptr = m_ptr + 1'b1; end
      default: ;
    endcase
  endtask

  int n_chk = 0, n_fail = 0;
  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_ops(input logic [5:0] m);
    {op_set, op_sel, op_wreg, op_wram, op_rh, op_rl} = m;
  endtask

  task automatic wait_ack(output int lat);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!ack && lat < 30);
  endtask

  task automatic do_op(input logic [5:0] mask, input logic [15:0] d,
                       output int lat, output int we_cnt, output logic [15:0] we_data);
    @(negedge clk);
    set_ops(mask); din = d;
    lat = 0; we_cnt = 0; we_data = '0;
    do begin
      @(negedge clk); lat++;
      if (vwe) begin we_cnt++; we_data = vdin; end
    end while (!ack && lat < 30);
    check("ack_rise", ack, 1);
    set_ops('0);
    @(negedge clk);
    check("ack_fall", ack, 0);
  endtask

  task automatic run_op(input string tag, input logic [5:0] mask, input logic [15:0] d);
    int lat, wc, elat; logic [15:0] wd; bit ewe;
    do_op(mask, d, lat, wc, wd);
    m_apply(mask, d, ewe, elat);
    check({tag, "_lat"}, lat, elat);
    check({tag, "_we_cnt"}, wc, ewe ? 1 : 0);
    if (ewe) check({tag, "_wdata"}, wd, d);
    check({tag, "_addr"}, vaddr, m_addr);
    check({tag, "_dout"}, dout, m_dout);
    check({tag, "_regs"}, regs, pack(m_regs));
  endtask

  typedef struct {
    logic [5:0] mask; logic [15:0] din; bit exp_we; logic [AW-1:0] exp_addr;
    logic [15:0] exp_dout; int exp_lat; bit reg_chk; int reg_idx; logic [15:0] reg_val;
  } vec_t;
  vec_t vt [17];

  initial begin
    int lat, wc, dlat, k; logic [15:0] wd; bit dwe;
    vt[0]  = '{M_SET,  16'h3FFE, 0, 14'h0000, 16'h0000, 3, 0, 0,  16'h0};
    vt[1]  = '{M_WRAM, 16'hA5A5, 1, 14'h3FFE, 16'h0000, 3, 0, 0,  16'h0};
    vt[2]  = '{M_WRAM, 16'h5A5A, 1, 14'h3FFF, 16'h0000, 3, 0, 0,  16'h0};
    vt[3]  = '{M_WRAM, 16'h1234, 1, 14'h0000, 16'h0000, 3, 0, 0,  16'h0};
    vt[4]  = '{M_SET,  16'hC100, 0, 14'h0000, 16'h0000, 3, 0, 0,  16'h0};
    vt[5]  = '{M_WRAM, 16'hBEEF, 1, 14'h0100, 16'h0000, 3, 0, 0,  16'h0};
    vt[6]  = '{M_WRAM, 16'hCAFE, 1, 14'h0101, 16'h0000, 3, 0, 0,  16'h0};
    vt[7]  = '{M_SET,  16'h0100, 0, 14'h0101, 16'h0000, 3, 0, 0,  16'h0};
    vt[8]  = '{M_RH,   16'h0000, 0, 14'h0100, 16'hBEEF, 4, 0, 0,  16'h0};
    vt[9]  = '{M_RL,   16'h0000, 0, 14'h0100, 16'hBEEF, 4, 0, 0,  16'h0};
    vt[10] = '{M_RH,   16'h0000, 0, 14'h0101, 16'hCAFE, 4, 0, 0,  16'h0};
    vt[11] = '{M_SEL,  16'h000F, 0, 14'h0101, 16'hCAFE, 3, 0, 0,  16'h0};
    vt[12] = '{M_WREG, 16'h8001, 0, 14'h0101, 16'hCAFE, 3, 1, 15, 16'h8001};
    vt[13] = '{M_SEL,  16'h0013, 0, 14'h0101, 16'hCAFE, 3, 0, 0,  16'h0};
    vt[14] = '{M_WREG, 16'h7777, 0, 14'h0101, 16'hCAFE, 3, 1, 3,  16'h7777};
    vt[15] = '{M_RL,   16'h0000, 0, 14'h0101, 16'hCAFE, 4, 0, 0,  16'h0};
    vt[16] = '{M_RH,   16'h0000, 0, 14'h0102, 16'h5B58, 4, 1, 15, 16'h8001};

    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ack", ack, 0);
    check("rst_dout", dout, 0);
    check("rst_we", vwe, 0);
    check("rst_addr", vaddr, 0);
    check("rst_regs", regs, 0);
    check("rst_frame", regs_frame, 0);
    rst = 1'b0;
    m_reset();

    for (int i = 0; i < 17; i++) begin
      do_op(vt[i].mask, vt[i].din, lat, wc, wd);
      m_apply(vt[i].mask, vt[i].din, dwe, dlat);
      check($sformatf("vec%0d_lat", i), lat, vt[i].exp_lat);
      check($sformatf("vec%0d_we_cnt", i), wc, vt[i].exp_we ? 1 : 0);
      if (vt[i].exp_we) check($sformatf("vec%0d_wdata", i), wd, vt[i].din);
      check($sformatf("vec%0d_addr", i), vaddr, vt[i].exp_addr);
      check($sformatf("vec%0d_dout", i), dout, vt[i].exp_dout);
      if (vt[i].reg_chk)
        check($sformatf("vec%0d_reg", i), regs[16*vt[i].reg_idx +: 16], vt[i].reg_val);
    end
    check("mem_3ffe", mem[14'h3FFE], 16'hA5A5);
    check("mem_3fff", mem[14'h3FFF], 16'h5A5A);
    check("mem_0000", mem[14'h0000], 16'h1234);

    // Held op: ACK stays high, one write only; ACK drops one clock after release.
    run_op("sel5", M_SEL, 16'h0005);
    @(negedge clk); op_wreg = 1'b1; din = 16'h1111;
    wait_ack(k);
    check("hold_ack_rise", ack, 1);
    m_apply(M_WREG, 16'h1111, dwe, dlat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_ack", ack, 1);
    end
    check("hold_regs", regs, pack(m_regs));
    op_wreg = 1'b0;
    @(negedge clk);
    check("hold_ack_fall", ack, 0);

    run_op("prio", M_SET | M_WRAM, 16'h0200);
    run_op("prio_wr", M_WRAM, 16'hABCD);
    check("prio_wr_addr", vaddr, 14'h0200);

    // Frame latch, including WRITE_REG EXEC on the LVBL falling edge.
    run_op("sel2", M_SEL, 16'h0002);
    run_op("wr40", M_WREG, 16'h0040);
    @(negedge clk); lvbl = 1'b0;
    for (int i = 0; i < NREG; i++) m_frame[i] = m_regs[i];
    repeat (2) @(negedge clk);
    check("frame_first", regs_frame[32 +: 16], 16'h0040);
    lvbl = 1'b1;
    @(negedge clk); op_wreg = 1'b1; din = 16'h0080;
    @(posedge clk);
    @(negedge clk); lvbl = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("frame_coincide_old", regs_frame[32 +: 16], 16'h0040);
    check("frame_coincide_reg", regs[32 +: 16], 16'h0080);
    m_apply(M_WREG, 16'h0080, dwe, dlat);
    wait_ack(k);
    check("coincide_ack", ack, 1);
    op_wreg = 1'b0;
    @(negedge clk);
    check("coincide_ack_fall", ack, 0);
    repeat (3) @(negedge clk);
    check("frame_held_low", regs_frame, pack(m_frame));
    lvbl = 1'b1;
    repeat (2) @(negedge clk);
    lvbl = 1'b0;
    for (int i = 0; i < NREG; i++) m_frame[i] = m_regs[i];
    repeat (2) @(negedge clk);
    check("frame_next", regs_frame[32 +: 16], 16'h0080);
    lvbl = 1'b1;

    // Randomized ops (occasionally several strobes at once) with vblank pulses.
    for (int n = 0; n < 250; n++) begin
      logic [5:0] mask; logic [15:0] d;
      mask = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(1, 63))
                                         : 6'(1 << $urandom_range(0, 5));
      d = 16'($urandom);
      if (mask[5]) d[AW-1:0] = 14'h3FF8 + 14'($urandom_range(0, 15));
      run_op("rnd", mask, d);
      if ($urandom_range(0, 5) == 0) begin
        @(negedge clk); lvbl = 1'b0;
        for (int i = 0; i < NREG; i++) m_frame[i] = m_regs[i];
        repeat (2) @(negedge clk);
        check("rnd_frame", regs_frame, pack(m_frame));
        lvbl = 1'b1;
      end
    end

    // Reset asserted while a READ_L waits on VRAM.
    run_op("pre_wr", M_SET, 16'h0100);
    run_op("pre_wr2", M_WRAM, 16'hBEEF);
    run_op("pre_set", M_SET, 16'h0100);
    run_op("pre_rd", M_RH, 16'h0000);
    @(negedge clk); op_rl = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrd_ack", ack, 0);
    check("midrd_dout", dout, 0);
    check("midrd_we", vwe, 0);
    check("midrd_regs", regs, 0);
    op_rl = 1'b0;
    @(negedge clk); rst = 1'b0;
    m_reset();
    check("midrd_frame", regs_frame, 0);
    run_op("post_rl", M_RL, 16'h0000);
    check("post_rl_addr0", vaddr, 14'h0000);
    run_op("post_rh", M_RH, 16'h0000);
    check("post_rh_addr1", vaddr, 14'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
